// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-bit synchroniser, tick-based debouncer, edge and long-hold pulses
module btn_debounce #(
  parameter int WIDTH      = 4,
  parameter int STABLE_CNT = 4,
  parameter int HOLD_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] held
);

  localparam int DW = $clog2(STABLE_CNT + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  // dcnt value on the tick that completes a stable run
  localparam logic [DW-1:0] D_LAST = DW'(STABLE_CNT - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] H_PRE  = HW'(HOLD_TICKS - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [DW-1:0]    dcnt [WIDTH];
  logic [HW-1:0]    hcnt [WIDTH];
  logic [WIDTH-1:0] commit;

  // A bit commits when this tick completes STABLE_CNT consecutive mismatching samples
  always_comb begin
    commit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      commit[i] = tick && (s2[i] != level[i]) && (dcnt[i] == D_LAST);
    end
  end

  // Two-flop synchroniser, free-running regardless of tick
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce counters, debounced level and registered edge pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        dcnt[i] <= '0;
      end
    end else begin
      // Pulses coincide with the cycle the new level first appears
      rise <= commit & s2;
      fall <= commit & ~s2;
      for (int i = 0; i < WIDTH; i++) begin
        if (tick) begin
          if (s2[i] == level[i]) begin
            dcnt[i] <= '0;
          end else if (dcnt[i] == D_LAST) begin
            level[i] <= s2[i];
            dcnt[i]  <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + DW'(1);
          end
        end
      end
    end
  end

  // Hold counters: count ticks of steady high level, pulse once on reaching HOLD_TICKS
  always_ff @(posedge clk) begin
    if (reset) begin
      held <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        hcnt[i] <= '0;
      end
    end else begin
      held <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (!level[i] || commit[i]) begin
          // level low, or level falling this cycle: restart from zero
          hcnt[i] <= '0;
        end else if (tick && (hcnt[i] != H_MAX)) begin
          // saturation at H_MAX is what suppresses repeat pulses
          hcnt[i] <= hcnt[i] + HW'(1);
          if (hcnt[i] == H_PRE) begin
            held[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Input conditioner for the pushbuttons on `ui_in[7:4]`, upstream of the game state machine. It does four things per bit:
- synchronises each raw button bit;
- debounces it against a slow sample strobe;
- emits one-cycle press and release pulses;
- flags a long hold.

The game logic consumes `level`, `rise`, `fall` and `held` in place of raw button bits.

## Interface
Parameters:
- `WIDTH`, default 4: number of independent input bits.
- `STABLE_CNT`, default 4: consecutive sample ticks a new value must persist before `level` accepts it. Must be ≥1.
- `HOLD_TICKS`, default 10: sample ticks `level` must stay high before `held` pulses. Must be ≥1.

Ports:
- `clk`  in  1: system clock, the single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `tick`  in  1: sample strobe, one `clk` cycle wide (the tenths or display divider output). Tie it high to sample every cycle.
- `raw`  in  `WIDTH`: asynchronous button inputs, active-high.
- `level`  out  `WIDTH`: debounced state.
- `rise`  out  `WIDTH`: one-cycle pulse when a `level` bit goes 0→1.
- `fall`  out  `WIDTH`: one-cycle pulse when a `level` bit goes 1→0.
- `held`  out  `WIDTH`: one-cycle pulse when a bit has been high for `HOLD_TICKS` ticks.

## Operation
- **Synchroniser:** two flops per bit, `raw → s1 → s2`, clocked every cycle regardless of `tick`.
- **Debounce counter:** one per bit, `dcnt`, width `$clog2(STABLE_CNT+1)`. It updates only on `tick`:
  - `s2 == level`: `dcnt` ← 0.
  - `s2 != level` and `dcnt+1 < STABLE_CNT`: `dcnt` ← `dcnt+1`.
  - `s2 != level` and `dcnt+1 == STABLE_CNT`: `level` ← `s2`, `dcnt` ← 0.
- **Glitch rejection:** a mismatch shorter than `STABLE_CNT` consecutive ticks clears `dcnt`. `level` does not change.
- **Edge pulses:** `rise`/`fall` are registered. Each is high for exactly the one cycle in which the new `level` value first appears, and low otherwise.
- **Hold counter:** one per bit, `hcnt`, width `$clog2(HOLD_TICKS+1)`:
  - On `tick` with `level`=1 and no transition that tick: `hcnt` increments, saturating at `HOLD_TICKS`.
  - When `hcnt` becomes `HOLD_TICKS`, `held` pulses for one cycle. Saturation prevents a repeat pulse.
  - `hcnt` is cleared whenever `level` is 0 or on the cycle `level` falls. It counts again from 0 on the next press.
- **Bit independence:** bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses.
- **Ticks:** with `tick`=0, `dcnt` and `hcnt` hold and `level` cannot change. The synchroniser keeps running.

## Timing
- **Reset:** on the first `clk` edge with `reset`=1:
  - `s1`, `s2`, `level`, `dcnt`, `hcnt` clear to 0;
  - `rise`, `fall`, `held` read 0.
- **Reset mid-operation** discards any pending count. No `fall` pulse is generated for a `level` forced to 0 by reset.
- **Press latency, `tick` tied high:** `raw` changes before edge E0.
  - `s2` updates after E1.
  - Ticks at E2..E(STABLE_CNT+1) count the mismatch.
  - `level` and `rise` are visible after edge E(STABLE_CNT+1): E5 with defaults.
  - `rise` drops after E(STABLE_CNT+2).
- **Release** is symmetric: the same latency, with `fall`.
- **Hold latency, `tick` tied high:** `held` pulses after edge E(STABLE_CNT+1+HOLD_TICKS), i.e. E15 with defaults.
- **Sparse `tick`:** latency is 2 `clk` cycles of synchronisation plus `STABLE_CNT` tick edges.
- **Boundary:** a `tick` coincident with the edge where `s2` first mismatches counts toward `STABLE_CNT`.
- **Pulse spacing:** no output pulse is ever wider than one `clk` cycle. `rise` and `fall` on the same bit are always separated by at least `STABLE_CNT` ticks.

## Test plan
- **Clean press/release:** defaults, `tick`=1, `raw[0]` 0→1 before E0, held 20 cycles, then 0.
  - Required: `level[0]`=1 and `rise[0]` pulse after E5; `held[0]` pulse after E15; `fall[0]` pulse 5 edges after the release; no other pulses.
- **Bounce:** `raw[1]` toggles 1,0,1,0 on consecutive cycles, then stays 1.
  - Required: `level[1]` rises exactly 5 edges after the final stable 1; exactly one `rise[1]` pulse.
- **Sparse tick:** `tick` every 8th cycle, `raw[2]`=1 held 40 cycles.
  - Required: `level[2]` rises on the 4th tick after `s2` goes high.
  - Required: a 1-tick glitch (high for 8 cycles only) produces no `rise`.
- **Multi-bit:** `raw`=4'b1011 applied at once.
  - Required: `rise`=4'b1011 in a single cycle after E5; `level`=4'b1011.
- **Reset mid-count:** `reset` asserted after E3 of a press, released after 2 cycles.
  - Required: all outputs 0 during reset; count restarts, so `level` rises 5 edges after reset releases, given `raw` still high.
- **Hold boundary:** release after exactly 9 ticks high → no `held` pulse; 10 ticks high → one `held` pulse; held for 30 ticks → still only one pulse.
